// File: rtl/bsg_mem_1rw_sync_rd_buffer_if.sv
// Request, memory-port and read-response signals of the sync-read buffer.
// The slave modport is the buffer's view; the master modport is the surrounding logic's view.
interface bsg_mem_1rw_sync_rd_buffer_if #(
  parameter int unsigned width_p       = 8,
  parameter int unsigned els_p         = 16,
  parameter int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
);
  logic                     v_i;
  logic                     w_i;
  logic [addr_width_lp-1:0] addr_i;
  logic [width_p-1:0]       data_i;
  logic                     ready_and_o;
  logic                     mem_v_o;
  logic                     mem_w_o;
  logic [addr_width_lp-1:0] mem_addr_o;
  logic [width_p-1:0]       mem_data_o;
  logic [width_p-1:0]       mem_data_i;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     yumi_i;

  modport slave (
    input  v_i, w_i, addr_i, data_i, mem_data_i, yumi_i,
    output ready_and_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, v_o, data_o
  );

  modport master (
    output v_i, w_i, addr_i, data_i, mem_data_i, yumi_i,
    input  ready_and_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_mem_1rw_sync_rd_buffer.sv
// Credit-gated front end for a 1rw sync-read memory: read data lands in a 2-entry FIFO,
// or bypasses it when the FIFO is empty and the consumer takes it immediately.
module bsg_mem_1rw_sync_rd_buffer #(
  parameter int unsigned width_p       = 8,
  parameter int unsigned els_p         = 16,
  parameter int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input logic                          clk_i,
  input logic                          reset_i,
  bsg_mem_1rw_sync_rd_buffer_if.slave  bus_io
);

  logic [width_p-1:0] fifo_q [2];
  logic [1:0]         occ_q, occ_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               inflight_q, inflight_d;

  logic [1:0]         credits;
  logic               ready;
  logic               issue;
  logic               bypass;
  logic               enq;
  logic               deq;
  logic [addr_width_lp-1:0] addr;

  // A credit is held from read issue until the consumer takes the data.
  assign credits = occ_q + 2'(inflight_q);
  assign ready   = ~reset_i & (credits < 2'd2);
  assign issue   = bus_io.v_i & ready;
  assign bypass  = (occ_q == 2'd0) & inflight_q;
  assign enq     = inflight_q & ~(bypass & bus_io.yumi_i);
  assign deq     = bus_io.yumi_i & (occ_q != 2'd0);
  assign addr    = bus_io.addr_i;

  assign bus_io.ready_and_o = ready;
  assign bus_io.mem_v_o     = issue;
  assign bus_io.mem_w_o     = bus_io.w_i;
  assign bus_io.mem_addr_o  = addr;
  assign bus_io.mem_data_o  = bus_io.data_i;
  assign bus_io.v_o         = (occ_q != 2'd0) | inflight_q;
  assign bus_io.data_o      = (occ_q != 2'd0) ? fifo_q[rd_ptr_q] : bus_io.mem_data_i;

  always_comb begin
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q ^ deq;
    wr_ptr_d   = wr_ptr_q ^ enq;
    inflight_d = issue & ~bus_io.w_i;
    if (enq && !deq) begin
      occ_d = occ_q + 2'd1;
    end else if (deq && !enq) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      occ_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_q[wr_ptr_q] <= bus_io.mem_data_i;
    end
  end

`ifndef BSG_HIDE_FROM_SYNTHESIS
  yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(bus_io.yumi_i && !bus_io.v_o))
    else $error("yumi_i asserted while v_o is low");

  credit_bound: assert property (@(posedge clk_i) disable iff (reset_i) credits <= 2'd2)
    else $error("occupancy plus in-flight exceeds two");
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_rd_buffer.sv
// Directed and random checks of the sync-read buffer against a behavioural memory and
// an in-order scoreboard.
module tb_bsg_mem_1rw_sync_rd_buffer;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [7:0] mem_array [16];
  logic [7:0] ref_mem   [16];
  logic [7:0] exp_q     [$];

  bsg_mem_1rw_sync_rd_buffer_if #(.width_p(8), .els_p(16)) bus ();

  bsg_mem_1rw_sync_rd_buffer #(
    .width_p(8),
    .els_p  (16)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory behind the buffer.
  always @(posedge clk) begin
    if (bus.mem_v_o) begin
      if (bus.mem_w_o) mem_array[bus.mem_addr_o] <= bus.mem_data_o;
      else             bus.mem_data_i <= mem_array[bus.mem_addr_o];
    end
  end

  function automatic logic [7:0] init_val(input int k);
    logic [7:0] v;
    v = 8'((k + 1) * 17);
    if (k == 3) v = 8'hA5;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic cyc(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d,
                     input logic y);
    @(negedge clk);
    bus.v_i    = v;
    bus.w_i    = w;
    bus.addr_i = a;
    bus.data_i = d;
    bus.yumi_i = y;
    #1;
  endtask

  initial begin
    logic [7:0] rv;
    logic       ev, ew, ey;
    logic [3:0] ea;
    logic [7:0] ed;
    bit         exp_ready;

    reset        = 1'b1;
    bus.v_i      = 1'b1;
    bus.w_i      = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    bus.yumi_i   = 1'b0;
    bus.mem_data_i = '0;
    #2;
    chk("rst_ready", 32'(bus.ready_and_o), 0);
    chk("rst_v_o", 32'(bus.v_o), 0);
    chk("rst_mem_v", 32'(bus.mem_v_o), 0);
    @(negedge clk);
    @(negedge clk);
    bus.v_i = 1'b0;
    reset   = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.ready_and_o), 1);

    // Preload through the write path; writes consume no credit and produce no output.
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b1, 4'(k), 8'(((k + 1) * 17) & 8'hFF), 1'b0);
      if (k == 0) begin
        chk("wr_mem_v", 32'(bus.mem_v_o), 1);
        chk("wr_mem_w", 32'(bus.mem_w_o), 1);
        chk("wr_mem_data", 32'(bus.mem_data_o), 32'h11);
      end
      if (k == 1) chk("wr_no_v_o", 32'(bus.v_o), 0);
    end
    cyc(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
    chk("wr_mem_addr", 32'(bus.mem_addr_o), 3);
    for (int k = 0; k < 16; k++) ref_mem[k] = init_val(k);

    // Single read with bypass.
    cyc(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    chk("byp_issue_v_o", 32'(bus.v_o), 0);
    chk("byp_issue_mem_v", 32'(bus.mem_v_o), 1);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("byp_v_o", 32'(bus.v_o), 1);
    chk("byp_data", 32'(bus.data_o), 32'hA5);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("byp_after_v_o", 32'(bus.v_o), 0);
    chk("byp_after_ready", 32'(bus.ready_and_o), 1);

    // Stall fill: two reads, nobody consuming.
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("fill_mem_v0", 32'(bus.mem_v_o), 1);
    cyc(1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
    chk("fill_ready1", 32'(bus.ready_and_o), 1);
    chk("fill_data_byp", 32'(bus.data_o), 32'h11);
    cyc(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    chk("fill_ready_full", 32'(bus.ready_and_o), 0);
    chk("fill_mem_v_stall", 32'(bus.mem_v_o), 0);
    chk("fill_v_o", 32'(bus.v_o), 1);
    chk("fill_data", 32'(bus.data_o), 32'h11);
    cyc(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    chk("fill_ready_full2", 32'(bus.ready_and_o), 0);
    chk("fill_mem_v_stall2", 32'(bus.mem_v_o), 0);
    chk("fill_data2", 32'(bus.data_o), 32'h11);

    // Drain in issue order.
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("drain_data0", 32'(bus.data_o), 32'h11);
    chk("drain_ready0", 32'(bus.ready_and_o), 0);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("drain_data1", 32'(bus.data_o), 32'h22);
    chk("drain_ready1", 32'(bus.ready_and_o), 1);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("drain_empty", 32'(bus.v_o), 0);

    // Reset with a full FIFO.
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("full_before_rst", 32'(bus.ready_and_o), 0);
    reset = 1'b1;
    #1;
    chk("midrst_v_o", 32'(bus.v_o), 0);
    chk("midrst_ready", 32'(bus.ready_and_o), 0);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_rel_ready", 32'(bus.ready_and_o), 1);
    chk("midrst_rel_v_o", 32'(bus.v_o), 0);

    // Reset with a read in flight: the response is dropped.
    cyc(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    chk("infl_rst_v_o", 32'(bus.v_o), 0);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    chk("infl_rel_v_o", 32'(bus.v_o), 0);
    chk("infl_rel_ready", 32'(bus.ready_and_o), 1);

    // Streaming: one read per cycle with yumi held high.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 4'(i), 8'h00, (i > 0) ? 1'b1 : 1'b0);
      chk($sformatf("stream_ready%0d", i), 32'(bus.ready_and_o), 1);
      if (i > 0) begin
        chk($sformatf("stream_v%0d", i - 1), 32'(bus.v_o), 1);
        chk($sformatf("stream_data%0d", i - 1), 32'(bus.data_o), 32'(init_val(i - 1)));
      end
    end
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("stream_v15", 32'(bus.v_o), 1);
    chk("stream_data15", 32'(bus.data_o), 32'(init_val(15)));
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("stream_empty", 32'(bus.v_o), 0);

    // Random traffic against the scoreboard; queue depth equals occupancy plus in-flight.
    for (int t = 0; t < 400; t++) begin
      ev = 1'($urandom_range(0, 1));
      ew = ($urandom_range(0, 3) == 0);
      ea = 4'($urandom_range(0, 15));
      ed = 8'($urandom);
      ey = (exp_q.size() != 0) && ($urandom_range(0, 2) != 0);
      cyc(ev, ew, ea, ed, ey);
      exp_ready = (exp_q.size() < 2);
      chk("rnd_ready", 32'(bus.ready_and_o), 32'(exp_ready));
      chk("rnd_v_o", 32'(bus.v_o), 32'(exp_q.size() != 0));
      chk("rnd_mem_v", 32'(bus.mem_v_o), 32'(ev & exp_ready));
      chk("rnd_credit_bound", 32'(exp_q.size() <= 2), 1);
      if (ey) begin
        rv = exp_q.pop_front();
        chk("rnd_data", 32'(bus.data_o), 32'(rv));
      end
      if (ev && exp_ready) begin
        if (ew) ref_mem[ea] = ed;
        else    exp_q.push_back(ref_mem[ea]);
      end
    end

    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      rv = exp_q.pop_front();
      chk("drain_rnd_data", 32'(bus.data_o), 32'(rv));
    end
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("final_v_o", 32'(bus.v_o), 0);
    chk("final_ready", 32'(bus.ready_and_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
